// File: rtl/io_input_cond_if.sv
// Bus between the raw board inputs / MMIO side and the input conditioner.
// The board/CPU side uses master; the conditioner uses slave.
interface io_input_cond_if #(
   parameter int unsigned NUM_BTN  = 5,
   parameter int unsigned SW_WIDTH = 24
);
   logic [NUM_BTN-1:0]  btn_raw;
   logic [SW_WIDTH-1:0] sw_raw;
   logic [NUM_BTN-1:0]  sticky_clr;
   logic [NUM_BTN-1:0]  btn_level;
   logic [NUM_BTN-1:0]  btn_rise;
   logic [NUM_BTN-1:0]  btn_fall;
   logic [NUM_BTN-1:0]  btn_sticky;
   logic [SW_WIDTH-1:0] sw_sync;
   logic                sw_changed;

   modport master (
      output btn_raw, sw_raw, sticky_clr,
      input  btn_level, btn_rise, btn_fall, btn_sticky, sw_sync, sw_changed
   );

   modport slave (
      input  btn_raw, sw_raw, sticky_clr,
      output btn_level, btn_rise, btn_fall, btn_sticky, sw_sync, sw_changed
   );
endinterface

// File: rtl/io_input_cond.sv
// Input conditioner: two-flop synchronisers for buttons and switches, per-channel
// button debounce with rise/fall pulses and sticky press flags, switch change pulse.
module io_input_cond #(
   parameter int unsigned NUM_BTN         = 5,
   parameter int unsigned SW_WIDTH        = 24,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input logic              cpuclk,
   input logic              rst_n,
   io_input_cond_if.slave   io
);
   localparam int unsigned        CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]   TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0]  btn_s1;
   logic [NUM_BTN-1:0]  btn_s2;
   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;

   logic [NUM_BTN-1:0]  stable;
   logic [NUM_BTN-1:0]  stable_next;
   logic [CNT_W-1:0]    cnt      [NUM_BTN];
   logic [CNT_W-1:0]    cnt_next [NUM_BTN];
   logic [NUM_BTN-1:0]  rise_q;
   logic [NUM_BTN-1:0]  rise_next;
   logic [NUM_BTN-1:0]  fall_q;
   logic [NUM_BTN-1:0]  fall_next;
   logic [NUM_BTN-1:0]  sticky_q;
   logic [NUM_BTN-1:0]  sticky_next;
   logic                sw_changed_q;

   // Plain synchroniser chains: nothing may sit between s1 and s2.
   always_ff @(posedge cpuclk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= io.btn_raw;
         btn_s2 <= btn_s1;
         sw_s1  <= io.sw_raw;
         sw_s2  <= sw_s1;
      end
   end

   // A change is accepted only after s2 differs from stable on DEBOUNCE_CYCLES
   // consecutive edges; any return to stable restarts the count.
   always_comb begin
      stable_next = stable;
      cnt_next    = cnt;
      rise_next   = '0;
      fall_next   = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (btn_s2[i] == stable[i]) begin
            cnt_next[i] = '0;
         end else if (cnt[i] == TERM) begin
            cnt_next[i]    = '0;
            stable_next[i] = btn_s2[i];
            rise_next[i]   = btn_s2[i];
            fall_next[i]   = ~btn_s2[i];
         end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
         end
      end
      // Set wins over a same-edge clear.
      sticky_next = (sticky_q & ~io.sticky_clr) | rise_next;
   end

   always_ff @(posedge cpuclk or negedge rst_n) begin
      if (!rst_n) begin
         stable   <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         sticky_q <= '0;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable   <= stable_next;
         rise_q   <= rise_next;
         fall_q   <= fall_next;
         sticky_q <= sticky_next;
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   // Compare s1 against s2 so the pulse lines up with the first cycle of new sw_sync.
   always_ff @(posedge cpuclk or negedge rst_n) begin
      if (!rst_n) begin
         sw_changed_q <= 1'b0;
      end else begin
         sw_changed_q <= |(sw_s1 ^ sw_s2);
      end
   end

   assign io.btn_level  = stable;
   assign io.btn_rise   = rise_q;
   assign io.btn_fall   = fall_q;
   assign io.btn_sticky = sticky_q;
   assign io.sw_sync    = sw_s2;
   assign io.sw_changed = sw_changed_q;
endmodule

// File: tb/tb_io_input_cond.sv
// Self-checking bench for io_input_cond: directed scenarios followed by random
// stimulus, all compared against a sample-window reference model.
module tb_io_input_cond;
   localparam int unsigned NB = 5;
   localparam int unsigned SW = 24;
   localparam int unsigned D  = 4;

   logic cpuclk = 1'b0;
   logic rst_n;

   io_input_cond_if #(.NUM_BTN(NB), .SW_WIDTH(SW)) bus ();

   io_input_cond #(
      .NUM_BTN(NB),
      .SW_WIDTH(SW),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .cpuclk(cpuclk),
      .rst_n(rst_n),
      .io(bus)
   );

   always #5 cpuclk = ~cpuclk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: raw samples per edge, newest at index 0.
   logic [NB-1:0] bh [0:D+1];
   logic [SW-1:0] sh [0:2];
   logic [NB-1:0] m_lvl, m_rise, m_fall, m_sticky;
   logic [SW-1:0] m_sw;
   logic          m_chg;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k <= int'(D) + 1; k++) bh[k] = '0;
      for (int k = 0; k < 3; k++) sh[k] = '0;
      m_lvl = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
      m_sw = '0; m_chg = 1'b0;
   endtask

   // Level flips once the last D synchronised samples all disagree with it.
   // The sample compared at edge n is the raw value applied at edge n-2.
   task automatic model_edge(input logic [NB-1:0] b, input logic [SW-1:0] s, input logic [NB-1:0] c);
      logic all_diff;
      for (int k = int'(D) + 1; k > 0; k--) bh[k] = bh[k-1];
      bh[0] = b;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < int'(NB); i++) begin
         all_diff = 1'b1;
         for (int k = 2; k <= int'(D) + 1; k++)
            if (bh[k][i] == m_lvl[i]) all_diff = 1'b0;
         if (all_diff) begin
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) m_rise[i] = 1'b1;
            else          m_fall[i] = 1'b1;
         end
      end
      m_sticky = (m_sticky & ~c) | m_rise;
      sh[2] = sh[1];
      sh[1] = sh[0];
      sh[0] = s;
      m_sw  = sh[1];
      m_chg = (sh[1] != sh[2]);
   endtask

   task automatic check_all();
      chk("btn_level",  64'(bus.btn_level),  64'(m_lvl));
      chk("btn_rise",   64'(bus.btn_rise),   64'(m_rise));
      chk("btn_fall",   64'(bus.btn_fall),   64'(m_fall));
      chk("btn_sticky", 64'(bus.btn_sticky), 64'(m_sticky));
      chk("sw_sync",    64'(bus.sw_sync),    64'(m_sw));
      chk("sw_changed", 64'(bus.sw_changed), 64'(m_chg));
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic [NB-1:0] b, input logic [SW-1:0] s, input logic [NB-1:0] c);
      bus.btn_raw    = b;
      bus.sw_raw     = s;
      bus.sticky_clr = c;
      @(posedge cpuclk);
      model_edge(b, s, c);
      #1 check_all();
      @(negedge cpuclk);
   endtask

   initial begin
      int first;
      int nrise;
      int npulse;
      logic [NB-1:0] tgt;
      logic [NB-1:0] raw;
      logic [NB-1:0] clr;
      logic [SW-1:0] sw;

      rst_n = 1'b0;
      bus.btn_raw = '0; bus.sw_raw = '0; bus.sticky_clr = '0;
      model_reset();
      #1 check_all();
      repeat (2) @(negedge cpuclk);
      rst_n = 1'b1;

      // Clean press and release on channel 0
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         step(5'b00001, '0, '0);
         if (bus.btn_rise[0] && first < 0) first = k;
      end
      chk("press_rise_edge", 64'(first), 64'(6));
      chk("press_sticky0", 64'(bus.btn_sticky[0]), 64'(1));
      first = -1;
      for (int k = 1; k <= 8; k++) begin
         step('0, '0, '0);
         if (bus.btn_fall[0] && first < 0) first = k;
      end
      chk("release_fall_edge", 64'(first), 64'(6));

      // Bounce on channel 1, then a clean hold
      nrise = 0;
      for (int k = 0; k < 8; k++) begin
         step(((k % 4) < 2) ? 5'b00010 : 5'b00000, '0, '0);
         if (bus.btn_rise[1]) nrise++;
      end
      chk("bounce_no_rise", 64'(nrise), 64'(0));
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         step(5'b00010, '0, '0);
         if (bus.btn_rise[1]) begin
            nrise++;
            if (first < 0) first = k;
         end
      end
      chk("bounce_hold_rise_edge", 64'(first), 64'(6));
      chk("bounce_single_rise", 64'(nrise), 64'(1));
      repeat (8) step('0, '0, '0);

      // Sticky clear on channel 2, with and without a coincident rise
      repeat (6) step(5'b00100, '0, '0);
      chk("sticky2_set", 64'(bus.btn_sticky[2]), 64'(1));
      step(5'b00100, '0, 5'b00100);
      chk("sticky2_cleared", 64'(bus.btn_sticky[2]), 64'(0));
      repeat (8) step('0, '0, '0);
      repeat (5) step(5'b00100, '0, '0);
      step(5'b00100, '0, 5'b00100);
      chk("race_rise2", 64'(bus.btn_rise[2]), 64'(1));
      chk("race_sticky2", 64'(bus.btn_sticky[2]), 64'(1));
      repeat (8) step('0, '0, '0);

      // Simultaneous channels
      repeat (5) step(5'b10101, '0, '0);
      step(5'b10101, '0, '0);
      chk("simul_rise", 64'(bus.btn_rise), 64'(5'b10101));
      chk("simul_level", 64'(bus.btn_level), 64'(5'b10101));
      repeat (8) step('0, '0, '0);

      // Switch change
      first = -1;
      npulse = 0;
      for (int k = 1; k <= 8; k++) begin
         step('0, 24'h000007, '0);
         if (bus.sw_changed) begin
            npulse++;
            if (first < 0) first = k;
         end
         if (k == 2) chk("sw_sync_value", 64'(bus.sw_sync), 64'h7);
      end
      chk("sw_pulse_edge", 64'(first), 64'(2));
      chk("sw_pulse_count", 64'(npulse), 64'(1));

      // Reset in the middle of a debounce count on channel 3
      repeat (4) step(5'b01000, 24'h000007, '0);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge cpuclk);
      rst_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 8; k++) begin
         step(5'b01000, 24'h000007, '0);
         if (bus.btn_rise[3] && first < 0) first = k;
      end
      chk("reset_rise_edge", 64'(first), 64'(6));

      // Random buttons with bounce, random clears and switch activity
      tgt = 5'b01000;
      sw  = 24'h000007;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < int'(NB); i++)
            if ($urandom_range(19) == 0) tgt[i] = ~tgt[i];
         raw = tgt;
         clr = '0;
         for (int i = 0; i < int'(NB); i++) begin
            if ($urandom_range(5) == 0) raw[i] = ~raw[i];
            if ($urandom_range(3) == 0) clr[i] = 1'b1;
         end
         if (k >= 200 && k < 212) sw = sw + 24'd1;
         else if ($urandom_range(7) == 0) sw = 24'($urandom);
         step(raw, sw, clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/io_input_cond.md
# io_input_cond

Parametrised input conditioner between the board's raw push-buttons/DIP switches and the CPU's memory-mapped I/O. Every input passes through a two-flop synchroniser. Buttons are then debounced per channel, yielding a clean level, one-cycle rise/fall pulses and software-clearable sticky press flags. Switches are synchronised only and report a one-cycle change pulse.

## Interface
- NUM_BTN, 5, number of button channels (≥1)
- SW_WIDTH, 24, switch bus width (≥1)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button change (≥1); counter width CNT_W = $clog2(DEBOUNCE_CYCLES+1)
- cpuclk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  NUM_BTN  raw button inputs, asynchronous to cpuclk
- sw_raw  in  SW_WIDTH  raw switch inputs, asynchronous to cpuclk
- sticky_clr  in  NUM_BTN  per-channel clear of btn_sticky (one-cycle write strobe from MMIO)
- btn_level  out  NUM_BTN  debounced button level
- btn_rise  out  NUM_BTN  one-cycle pulse when btn_level goes 0→1
- btn_fall  out  NUM_BTN  one-cycle pulse when btn_level goes 1→0
- btn_sticky  out  NUM_BTN  set by btn_rise, held until cleared
- sw_sync  out  SW_WIDTH  synchronised switch value
- sw_changed  out  1  one-cycle pulse when any sw_sync bit changes

## Operation
- Synchroniser: s1 <= raw, s2 <= s1 for every button and switch bit. No logic sits between s1 and s2.
- Per button channel: stable flop (drives btn_level) and counter cnt[CNT_W].
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, and btn_rise (or btn_fall) <= 1 on the same edge. Otherwise rise/fall <= 0.
- Glitch rejection: if s2 returns to stable before the terminal count, cnt clears and no output changes.
- Sticky: btn_sticky[i] <= (btn_sticky[i] & ~sticky_clr[i]) | rise_next[i]. When a set and a clear occur on the same edge, the set wins.
- Switches: sw_sync = s2. The registered sw_changed <= |(s1 ^ s2), so the pulse coincides with the first cycle of the new sw_sync.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset (async assert, sync release via cpuclk edges): s1, s2, stable, cnt, btn_rise, btn_fall, btn_sticky, sw_changed all 0. Therefore btn_level=0 and sw_sync=0.
- Button latency, with btn_raw changed and held from before edge E:
  - s2 holds the new value after edge E+1.
  - btn_level and the rise/fall pulse update at edge E+DEBOUNCE_CYCLES+1.
  - The pulse is high for exactly one cycle.
- Minimum accepted pulse width: a raw level must hold DEBOUNCE_CYCLES+... consecutive s2 samples. Specifically, s2 must differ from stable on DEBOUNCE_CYCLES consecutive edges.
- Switch latency: sw_sync updates at edge E+1; sw_changed is high during the following cycle only. If a switch changes every cycle, sw_changed stays high continuously.
- Reset mid-count: the count is discarded. If raw is high when reset releases, treat it as a fresh 0→1 transition, producing btn_rise DEBOUNCE_CYCLES+2 edges after release.
- A held button produces exactly one rise and no further pulses. The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- DEBOUNCE_CYCLES=1: a change is accepted on the first edge at which s2 differs. Latency is 2 edges.

## Test plan
- Clean press/release (DEBOUNCE_CYCLES=4, NUM_BTN=5): btn_raw[0] 0→1 before edge 10 and held 20 cycles, then 1→0 → btn_level[0] rises at edge 15. btn_rise[0] is high for the single cycle after edge 15. btn_sticky[0]=1. btn_fall[0] pulses 5 edges after the release. Other channels stay 0.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 with 2-cycle widths, then holds at 1 → no pulse during the bounce. Exactly one btn_rise[1], at hold-start edge + 5.
- Sticky clear races: sticky_clr[2]=1 on a cycle with no rise → btn_sticky[2] goes to 0. sticky_clr[2]=1 on the same edge as btn_rise[2] → btn_sticky[2] stays 1.
- Simultaneous channels: btn_raw=5'b10101 in one cycle → btn_rise=5'b10101 in one identical cycle, and btn_level=5'b10101.
- Switches: sw_raw 0→24'h000007 at edge 20 → sw_sync=24'h000007 after edge 21. sw_changed is high for exactly one cycle, coincident with that update. With sw_raw held, no further pulses.
- Reset mid-debounce: btn_raw[3]=1 is held, and rst_n is pulsed low for 1 cycle at count 2 → all outputs 0 immediately on rst_n falling, not on a clock edge. btn_rise[3] occurs 6 edges after release.
